// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// The owner enum records which requester a pending read belongs to.
package mem_arb_pkg;

    localparam int DEFAULT_ADDR_W = 12;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_IDLE    = 2'd0,
        OWN_CORE_RD = 2'd1,
        OWN_HOST_RD = 2'd2
    } owner_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive host arbitration losses.
// Clear has priority over increment.
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [3:0] LIMIT_C = 4'(LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/data_mem_arbiter.sv
// Core/host arbiter for the single-port data memory, with starvation
// guarantee for the host and per-read ownership tracking for returned data.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    logic host_win;
    logic core_win;
    logic at_limit;

    owner_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    assign host_win   = host_req & (~core_req | at_limit);
    assign core_win   = core_req & ~host_win;
    assign host_gnt   = host_win;
    assign core_stall = core_req & host_win;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .CLK      (CLK),
        .reset    (reset),
        .inc      (host_req & core_win),
        .clr      (host_win | ~host_req),
        .at_limit (at_limit)
    );

    // Address and write data hold through idle cycles so the memory pins stay quiet.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we     = 1'b0;
        state_d    = OWN_IDLE;
        if (host_win) begin
            mem_addr_d = host_addr;
            mem_din_d  = host_wdata;
            mem_we     = host_we;
            if (!host_we) state_d = OWN_HOST_RD;
        end else if (core_win) begin
            mem_addr_d = core_addr;
            mem_din_d  = core_wdata;
            mem_we     = core_we;
            if (!core_we) state_d = OWN_CORE_RD;
        end
    end

    assign mem_addr = mem_addr_d;
    assign mem_din  = mem_din_d;

    // Returned data passes straight through in its valid cycle and is then held.
    always_comb begin
        core_rdata_d = core_rdata_q;
        host_rdata_d = host_rdata_q;
        if (state_q == OWN_CORE_RD) core_rdata_d = mem_dout;
        if (state_q == OWN_HOST_RD) host_rdata_d = mem_dout;
    end

    assign core_rdata  = core_rdata_d;
    assign host_rdata  = host_rdata_d;
    assign core_rvalid = (state_q == OWN_CORE_RD);
    assign host_rvalid = (state_q == OWN_HOST_RD);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= OWN_IDLE;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a synchronous-read memory model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_data_mem_arbiter;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [11:0] core_addr = '0;
    logic [15:0] core_wdata = '0;
    logic        core_stall, core_rvalid;
    logic [15:0] core_rdata;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [11:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_gnt, host_rvalid;
    logic [15:0] host_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_din;
    logic [15:0] mem_dout = '0;

    int assertCount = 0;
    int failCount = 0;

    bit          wrValid [0:4095];
    logic [15:0] wrData  [0:4095];

    data_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_stall(core_stall),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] preloadWord(input logic [11:0] a);
        case (a)
            12'h010: return 16'hBEEF;
            12'h001: return 16'hAAAA;
            12'h002: return 16'h5555;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge CLK) begin
        mem_dout <= wrValid[mem_addr] ? wrData[mem_addr] : preloadWord(mem_addr);
        if (mem_we) begin
            wrValid[mem_addr] <= 1'b1;
            wrData[mem_addr]  <= mem_din;
        end
    end

    task automatic applyStimulus(input logic rst,
                                 input logic cReq, input logic cWe, input logic [11:0] cAddr, input logic [15:0] cData,
                                 input logic hReq, input logic hWe, input logic [11:0] hAddr, input logic [15:0] hData);
        @(negedge CLK);
        reset = rst;
        core_req = cReq; core_we = cWe; core_addr = cAddr; core_wdata = cData;
        host_req = hReq; host_we = hWe; host_addr = hAddr; host_wdata = hData;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        checkOutput("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        checkOutput("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        checkOutput("rst_core_rdata", 32'(core_rdata), 32'h0);
        checkOutput("rst_host_rdata", 32'(host_rdata), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_din", 32'(mem_din), 32'h0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_host_gnt", 32'(host_gnt), 32'd0);
        checkOutput("rst_core_stall", 32'(core_stall), 32'd0);
        idleCycle();

        // Core-only read of 0x010
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        checkOutput("t1_stall", 32'(core_stall), 32'd0);
        checkOutput("t1_mem_addr", 32'(mem_addr), 32'h010);
        checkOutput("t1_mem_we", 32'(mem_we), 32'd0);
        idleCycle();
        checkOutput("t1_core_rvalid", 32'(core_rvalid), 32'd1);
        checkOutput("t1_core_rdata", 32'(core_rdata), 32'hBEEF);
        checkOutput("t1_host_rvalid", 32'(host_rvalid), 32'd0);
        idleCycle();
        checkOutput("t1_rvalid_pulse", 32'(core_rvalid), 32'd0);
        checkOutput("t1_rdata_hold", 32'(core_rdata), 32'hBEEF);
        checkOutput("t1_addr_hold", 32'(mem_addr), 32'h010);

        // Host write then host read of 0x020
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h020, 16'h1234);
        checkOutput("t2_wr_gnt", 32'(host_gnt), 32'd1);
        checkOutput("t2_wr_we", 32'(mem_we), 32'd1);
        checkOutput("t2_wr_din", 32'(mem_din), 32'h1234);
        checkOutput("t2_wr_addr", 32'(mem_addr), 32'h020);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h020, 16'h0000);
        checkOutput("t2_rd_gnt", 32'(host_gnt), 32'd1);
        checkOutput("t2_rd_we", 32'(mem_we), 32'd0);
        checkOutput("t2_no_wr_rvalid", 32'(host_rvalid), 32'd0);
        idleCycle();
        checkOutput("t2_host_rvalid", 32'(host_rvalid), 32'd1);
        checkOutput("t2_host_rdata", 32'(host_rdata), 32'h1234);
        checkOutput("t2_core_rvalid", 32'(core_rvalid), 32'd0);

        // Continuous contention: host forced through every 5th cycle
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, 1'b0, 12'h002, 16'h0000);
            checkOutput($sformatf("t3_gnt_%0d", i), 32'(host_gnt), 32'((i % 5) == 4));
            checkOutput($sformatf("t3_stall_%0d", i), 32'(core_stall), 32'((i % 5) == 4));
            if (i > 0) begin
                checkOutput($sformatf("t3_hrv_%0d", i), 32'(host_rvalid), 32'(((i - 1) % 5) == 4));
                checkOutput($sformatf("t3_crv_%0d", i), 32'(core_rvalid), 32'(((i - 1) % 5) != 4));
            end
        end
        idleCycle();
        checkOutput("t3_last_hrv", 32'(host_rvalid), 32'd1);
        checkOutput("t3_last_hrdata", 32'(host_rdata), 32'h5555);

        // Alternating owners on consecutive cycles
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h001, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h002, 16'h0000);
        checkOutput("t4_a_crv", 32'(core_rvalid), 32'd1);
        checkOutput("t4_a_cdata", 32'(core_rdata), 32'hAAAA);
        checkOutput("t4_a_hrv", 32'(host_rvalid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        checkOutput("t4_b_hrv", 32'(host_rvalid), 32'd1);
        checkOutput("t4_b_hdata", 32'(host_rdata), 32'h5555);
        checkOutput("t4_b_crv", 32'(core_rvalid), 32'd0);
        checkOutput("t4_b_chold", 32'(core_rdata), 32'hAAAA);
        idleCycle();
        checkOutput("t4_c_crv", 32'(core_rvalid), 32'd1);
        checkOutput("t4_c_cdata", 32'(core_rdata), 32'hBEEF);
        checkOutput("t4_c_hrv", 32'(host_rvalid), 32'd0);

        // Reset pulsed in the cycle after a granted core read
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h001, 16'h0000, 1'b1, 1'b0, 12'h002, 16'h0000);
        checkOutput("t5_core_wins", 32'(host_gnt), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        checkOutput("t5_rst_crv", 32'(core_rvalid), 32'd0);
        checkOutput("t5_rst_cdata", 32'(core_rdata), 32'h0);
        checkOutput("t5_rst_hdata", 32'(host_rdata), 32'h0);
        checkOutput("t5_rst_addr", 32'(mem_addr), 32'h0);
        checkOutput("t5_rst_din", 32'(mem_din), 32'h0);
        idleCycle();
        checkOutput("t5_post_crv", 32'(core_rvalid), 32'd0);
        checkOutput("t5_post_hrv", 32'(host_rvalid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, 1'b0, 12'h002, 16'h0000);
            checkOutput($sformatf("t5_gnt_%0d", k), 32'(host_gnt), 32'(k == 4));
        end
        idleCycle();

        // Host drops after 3 losses; counter restarts from zero
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, 1'b0, 12'h002, 16'h0000);
            checkOutput($sformatf("t6_lose_%0d", k), 32'(host_gnt), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h002, 16'h0000);
        checkOutput("t6_drop_gnt", 32'(host_gnt), 32'd0);
        checkOutput("t6_drop_stall", 32'(core_stall), 32'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, 1'b0, 12'h002, 16'h0000);
            checkOutput($sformatf("t6_gnt_%0d", k), 32'(host_gnt), 32'(k == 4));
            checkOutput($sformatf("t6_stall_%0d", k), 32'(core_stall), 32'(k == 4));
        end
        idleCycle();
        checkOutput("t6_idle_we", 32'(mem_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
